// File: rtl/test_monitor.sv
// Test-harness monitor: holds the core in reset, watches stores to the tohost word
// and latches a pass / fail / timeout verdict together with the elapsed RUN cycles.
module test_monitor #(
  parameter int                 RST_CYCLES  = 2,
  parameter int                 TIMEOUT     = 5000,
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR = ADDR_W'(32'h0000_1000),
  parameter int                 CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timed_out,
  output logic [DATA_W-2:0] test_num,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timed_out_q, timed_out_d;
  logic [DATA_W-2:0] test_num_q, test_num_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              report;
  logic              timeout_hit;

  always_comb begin
    report      = (state_q == RUN) && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    timeout_hit = (state_q == RUN) && (cycle_cnt_q == CNT_W'(TIMEOUT - 1));

    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timed_out_d = timed_out_q;
    test_num_d  = test_num_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      HOLD: begin
        hold_cnt_d  = hold_cnt_q + 8'(1);
        cycle_cnt_d = '0;
        if (hold_cnt_q == 8'(RST_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The report cycle itself is counted, so the counter advances on every RUN edge.
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (report) begin
          state_d = DONE;
          if (mem_wdata == DATA_W'(1)) begin
            pass_d     = 1'b1;
            test_num_d = '0;
          end else begin
            fail_d     = 1'b1;
            test_num_d = mem_wdata[DATA_W-1:1];
          end
        end else if (timeout_hit) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d     = HOLD;
        hold_cnt_d  = '0;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        timed_out_d = 1'b0;
        test_num_d  = '0;
        cycle_cnt_d = '0;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    core_rst_d = (state_d != RUN);
    running_d  = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      core_rst_q  <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timed_out_q <= 1'b0;
      test_num_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timed_out_q <= timed_out_d;
      test_num_q  <= test_num_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign running   = running_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timed_out = timed_out_q;
  assign test_num  = test_num_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: a short-timeout instance for vectors and random runs,
// plus a wide-data instance with a longer reset hold.
module tb_test_monitor;

  localparam int TO_A = 50;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
    logic        exp_pass;
    logic        exp_fail;
    logic        exp_to;
    logic [30:0] exp_num;
    logic [31:0] exp_cnt;
  } vec_t;

  logic clk;

  logic        rst_a, we_a;
  logic [31:0] addr_a, wdata_a;
  logic        core_rst_a, running_a, done_a, pass_a, fail_a, timed_out_a;
  logic [30:0] test_num_a;
  logic [31:0] cycle_cnt_a;

  logic        rst_b, we_b;
  logic [15:0] addr_b;
  logic [63:0] wdata_b;
  logic        core_rst_b, running_b, done_b, pass_b, fail_b, timed_out_b;
  logic [62:0] test_num_b;
  logic [31:0] cycle_cnt_b;

  int total = 0;
  int bad   = 0;

  vec_t vecs [9];

  test_monitor #(.TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .core_rst(core_rst_a), .running(running_a), .done(done_a), .pass(pass_a),
    .fail(fail_a), .timed_out(timed_out_a), .test_num(test_num_a), .cycle_cnt(cycle_cnt_a)
  );

  test_monitor #(.RST_CYCLES(5), .TIMEOUT(100), .ADDR_W(16), .DATA_W(64),
                 .TOHOST_ADDR(16'h8000)) dut_b (
    .clk(clk), .rst(rst_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .core_rst(core_rst_b), .running(running_b), .done(done_b), .pass(pass_b),
    .fail(fail_b), .timed_out(timed_out_b), .test_num(test_num_b), .cycle_cnt(cycle_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    we_a    = we;
    addr_a  = addr;
    wdata_a = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset on instance A and wait (bounded) until the core is released.
  task automatic reset_a_wait_run();
    bit ok;
    rst_a = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    step();
    rst_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (running_a) ok = 1'b1;
      else step();
    end
    if (!ok) checkOutput("wait_run_a", 64'(running_a), 64'd1);
  endtask

  task automatic check_result_a(input string tag, input logic ep, input logic ef, input logic et,
                                input logic [30:0] en, input logic [31:0] ec);
    checkOutput({tag, "_done"}, 64'(done_a), 64'd1);
    checkOutput({tag, "_pass"}, 64'(pass_a), 64'(ep));
    checkOutput({tag, "_fail"}, 64'(fail_a), 64'(ef));
    checkOutput({tag, "_tmo"},  64'(timed_out_a), 64'(et));
    checkOutput({tag, "_num"},  64'(test_num_a), 64'(en));
    checkOutput({tag, "_cnt"},  64'(cycle_cnt_a), 64'(ec));
    checkOutput({tag, "_crst"}, 64'({core_rst_a, running_a}), 64'b10);
  endtask

  initial begin
    logic        r_we   [TO_A];
    logic [31:0] r_addr [TO_A];
    logic [31:0] r_data [TO_A];
    int          k;
    int          hold_cycles;
    int          hit;
    logic        ep, ef, et;
    logic [30:0] en;
    logic [31:0] ec;
    logic [31:0] junk;

    vecs[0] = '{1'b1, 32'h1000, 32'h1,        40, 1'b1, 1'b0, 1'b0, 31'd0,          32'd41};
    vecs[1] = '{1'b1, 32'h1000, 32'h7,        10, 1'b0, 1'b1, 1'b0, 31'd3,          32'd11};
    vecs[2] = '{1'b1, 32'h1000, 32'h6,         5, 1'b0, 1'b0, 1'b1, 31'd0,          32'd50};
    vecs[3] = '{1'b1, 32'h1004, 32'h1,         5, 1'b0, 1'b0, 1'b1, 31'd0,          32'd50};
    vecs[4] = '{1'b0, 32'h1000, 32'h1,         5, 1'b0, 1'b0, 1'b1, 31'd0,          32'd50};
    vecs[5] = '{1'b1, 32'h1000, 32'h1,        49, 1'b1, 1'b0, 1'b0, 31'd0,          32'd50};
    vecs[6] = '{1'b1, 32'h1000, 32'h3,        49, 1'b0, 1'b1, 1'b0, 31'd1,          32'd50};
    vecs[7] = '{1'b1, 32'h1000, 32'h1,         0, 1'b1, 1'b0, 1'b0, 31'd0,          32'd1};
    vecs[8] = '{1'b1, 32'h1000, 32'hFFFF_FFFF, 48, 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd49};

    rst_a = 1'b1; rst_b = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    we_b = 1'b0; addr_b = 16'h0; wdata_b = 64'h0;
    step();
    step();

    // Reset sequence, with a valid-looking report during HOLD that must be ignored.
    rst_a = 1'b0;
    checkOutput("rst_flags", 64'({core_rst_a, running_a, done_a, pass_a, fail_a, timed_out_a}), 64'b100000);
    checkOutput("rst_num", 64'(test_num_a), 64'd0);
    checkOutput("rst_cnt", 64'(cycle_cnt_a), 64'd0);
    applyStimulus(1'b1, 32'h1000, 32'h1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("hold2_crst", 64'({core_rst_a, running_a}), 64'b10);
    step();
    checkOutput("run0_crst", 64'({core_rst_a, running_a}), 64'b01);
    for (int i = 0; i < 3; i++) begin
      checkOutput("run_count", 64'(cycle_cnt_a), 64'(i));
      step();
    end
    checkOutput("hold_store_ignored", 64'({done_a, pass_a}), 64'b00);

    // Vector table: one store at a given RUN cycle, then check the latched verdict.
    for (int v = 0; v < 9; v++) begin
      reset_a_wait_run();
      k = 0;
      while (!done_a && k < 100) begin
        if (k == vecs[v].at) applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].data);
        else applyStimulus(1'b0, 32'h0, 32'h0);
        step();
        k++;
      end
      applyStimulus(1'b0, 32'h0, 32'h0);
      check_result_a($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].exp_fail,
                     vecs[v].exp_to, vecs[v].exp_num, vecs[v].exp_cnt);
    end

    // Pass at cycle 40, then 100 cycles of stores in DONE that must not disturb the result.
    reset_a_wait_run();
    for (int i = 0; i < 40; i++) step();
    applyStimulus(1'b1, 32'h1000, 32'h1);
    step();
    for (int i = 0; i < 100; i++) begin
      checkOutput("done_flags", 64'({done_a, pass_a, fail_a, timed_out_a, core_rst_a, running_a}), 64'b110010);
      checkOutput("done_num", 64'(test_num_a), 64'd0);
      checkOutput("done_cnt", 64'(cycle_cnt_a), 64'd41);
      applyStimulus(1'b1, 32'h1000, (i % 2 == 0) ? 32'h7 : 32'h1);
      step();
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checkOutput("done_rst_flags", 64'({core_rst_a, running_a, done_a, pass_a, fail_a, timed_out_a}), 64'b100000);
    checkOutput("done_rst_cnt", 64'(cycle_cnt_a), 64'd0);

    // Ignored stores before a failing report.
    reset_a_wait_run();
    for (int i = 0; i < 9; i++) begin
      if (i == 3) applyStimulus(1'b1, 32'h1000, 32'h6);
      else if (i == 4) applyStimulus(1'b1, 32'h1004, 32'h1);
      else if (i == 8) applyStimulus(1'b1, 32'h1000, 32'h7);
      else applyStimulus(1'b0, 32'h0, 32'h0);
      if (i == 6) checkOutput("ignored_not_done", 64'(done_a), 64'd0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    check_result_a("seq_fail", 1'b0, 1'b1, 1'b0, 31'd3, 32'd9);

    // Mid-run reset at cycle 20.
    reset_a_wait_run();
    for (int i = 0; i < 20; i++) step();
    checkOutput("mid_cnt20", 64'(cycle_cnt_a), 64'd20);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checkOutput("mid_rst_flags", 64'({core_rst_a, running_a, done_a, pass_a, fail_a, timed_out_a}), 64'b100000);
    checkOutput("mid_rst_cnt", 64'(cycle_cnt_a), 64'd0);
    step();
    checkOutput("mid_hold2", 64'({core_rst_a, running_a}), 64'b10);
    step();
    checkOutput("mid_run", 64'({core_rst_a, running_a}), 64'b01);
    checkOutput("mid_run_cnt", 64'(cycle_cnt_a), 64'd0);

    // Random runs against a reference built from the store list.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < TO_A; i++) begin
        r_we[i]   = ($urandom_range(0, 3) == 0);
        junk      = $urandom;
        case ($urandom_range(0, 3))
          0:       r_addr[i] = 32'h1000;
          1:       r_addr[i] = 32'h1004;
          default: r_addr[i] = junk;
        endcase
        r_data[i] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
      end
      hit = -1;
      for (int i = 0; i < TO_A; i++) begin
        if (hit < 0 && r_we[i] && r_addr[i] == 32'h1000 && r_data[i][0]) hit = i;
      end
      if (hit >= 0) begin
        ep = (r_data[hit] == 32'h1);
        ef = !ep;
        et = 1'b0;
        en = ep ? 31'd0 : r_data[hit][31:1];
        ec = 32'(hit + 1);
      end else begin
        ep = 1'b0; ef = 1'b0; et = 1'b1; en = 31'd0; ec = 32'(TO_A);
      end
      reset_a_wait_run();
      k = 0;
      while (!done_a && k < TO_A + 10) begin
        checkOutput("rand_cnt", 64'(cycle_cnt_a), 64'(k));
        if (k < TO_A) applyStimulus(r_we[k], r_addr[k], r_data[k]);
        else applyStimulus(1'b0, 32'h0, 32'h0);
        step();
        k++;
      end
      applyStimulus(1'b0, 32'h0, 32'h0);
      check_result_a($sformatf("rand%0d", r), ep, ef, et, en, ec);
    end

    // Wide instance: 5-cycle hold, 64-bit data, 16-bit address.
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    hold_cycles = 0;
    for (int i = 0; i < 20 && !running_b; i++) begin
      if (core_rst_b) hold_cycles++;
      step();
    end
    checkOutput("b_hold_cycles", 64'(hold_cycles), 64'd5);
    checkOutput("b_running", 64'(running_b), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin we_b = 1'b1; addr_b = 16'h1000; wdata_b = 64'h1; end
      else if (i == 2) begin we_b = 1'b1; addr_b = 16'h8000; wdata_b = 64'h21; end
      else begin we_b = 1'b0; addr_b = 16'h0; wdata_b = 64'h0; end
      step();
    end
    we_b = 1'b0;
    checkOutput("b_flags", 64'({done_b, pass_b, fail_b, timed_out_b, core_rst_b}), 64'b10101);
    checkOutput("b_num", 64'(test_num_b), 64'd16);
    checkOutput("b_cnt", 64'(cycle_cnt_b), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2, number of cycles core_rst is held after rst releases (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 5000, number of RUN cycles allowed before a timeout (legal range >= 1).
REQ-003 SHALL have parameter ADDR_W, default 32, store address width.
REQ-004 SHALL have parameter DATA_W, default 32, store data width.
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, byte address of the tohost word.
REQ-006 SHALL have parameter CNT_W, default 32, width of the cycle counter.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-009 SHALL have port mem_we, input, 1 bit, core store strobe, one store per cycle high.
REQ-010 SHALL have port mem_addr, input, ADDR_W bits, store byte address.
REQ-011 SHALL have port mem_wdata, input, DATA_W bits, store data.
REQ-012 SHALL have port core_rst, output, 1 bit, reset driven to the core.
REQ-013 SHALL have port running, output, 1 bit, high in state RUN.
REQ-014 SHALL have port done, output, 1 bit, high in state DONE.
REQ-015 SHALL have port pass, output, 1 bit, test reported success.
REQ-016 SHALL have port fail, output, 1 bit, test reported failure.
REQ-017 SHALL have port timed_out, output, 1 bit, no report within TIMEOUT cycles.
REQ-018 SHALL have port test_num, output, DATA_W-1 bits, failing test number (mem_wdata >> 1).
REQ-019 SHALL have port cycle_cnt, output, CNT_W bits, RUN cycles elapsed.

Function
REQ-020 SHALL implement FSM states HOLD, RUN, DONE; any other encoding SHALL go to HOLD next cycle.
REQ-021 HOLD: core_rst=1; an internal hold counter increments each cycle; the FSM SHALL go to RUN on the cycle after the counter reaches RST_CYCLES-1, so core_rst is high for exactly RST_CYCLES cycles after rst deasserts.
REQ-022 RUN: core_rst=0, running=1; cycle_cnt SHALL increment by 1 each cycle, saturating at all-ones.
REQ-023 Report: in RUN, when mem_we=1, mem_addr==TOHOST_ADDR and mem_wdata[0]=1, the FSM SHALL enter DONE next cycle.
REQ-024 Report decode: mem_wdata==1 sets pass=1 and test_num=0; any other odd value sets fail=1 and test_num=mem_wdata>>1.
REQ-025 Writes to TOHOST_ADDR with mem_wdata[0]=0 SHALL be ignored. Writes to other addresses SHALL be ignored, as SHALL any store seen outside RUN.
REQ-026 Timeout: in RUN, when cycle_cnt==TIMEOUT-1 and no report is seen that cycle, timed_out SHALL be set and the FSM SHALL enter DONE next cycle.
REQ-027 If a report and the timeout condition occur in the same cycle, the report SHALL win; timed_out stays 0.
REQ-028 DONE: core_rst=1 (core frozen); done=1; pass, fail, timed_out, test_num and cycle_cnt SHALL hold until rst; further stores SHALL be ignored.
REQ-029 Exactly one of pass, fail or timed_out SHALL be 1 while done=1; all three SHALL be 0 while done=0.
REQ-030 cycle_cnt in DONE SHALL equal the number of RUN cycles, counting the report cycle.

Reset
REQ-031 rst=1 at a clock edge SHALL force the following: state=HOLD, hold counter=0, core_rst=1, running=0, done=0, pass=0, fail=0, timed_out=0, test_num=0, cycle_cnt=0.
REQ-032 rst asserted in any state, including mid-RUN or DONE, SHALL abort and restart the full sequence after release; no result SHALL survive it.
REQ-033 All outputs SHALL be registered, with no combinational path from mem_* inputs to outputs.

Verification
REQ-034 Reset sequence: RST_CYCLES=2, rst high 1 cycle then low -> core_rst high exactly 2 cycles after release, then running=1 and cycle_cnt counts 0,1,2...
REQ-035 Pass report: store of 32'h1 to 32'h1000 at cycle_cnt=40 -> next cycle done=1, pass=1, test_num=0, cycle_cnt=41, core_rst=1, and values hold for 100 cycles.
REQ-036 Fail report: store of 32'h7 to 32'h1000 -> fail=1, test_num=3. Also, a prior store of 32'h6 to 32'h1000 and a store of 32'h1 to 32'h1004 -> both ignored.
REQ-037 Timeout: TIMEOUT=50 with no stores -> done=1, timed_out=1, cycle_cnt=50. A variant storing 32'h1 to tohost at cycle_cnt=49 -> pass=1, timed_out=0.
REQ-038 Mid-run reset: rst pulsed at cycle_cnt=20 -> all outputs return to reset values, HOLD repeats for RST_CYCLES, and cycle_cnt restarts at 0.
REQ-039 Parameter sweep: ADDR_W=16, DATA_W=64, TOHOST_ADDR=16'h8000, RST_CYCLES=5 -> store of 64'h21 to 16'h8000 -> fail=1, test_num=16, core_rst was high for 5 cycles.
